// File: rtl/invaders_pkg.sv
// Shared constants and types for the invaders playfield logic.
package invaders_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned OFFSCREEN_X = 641;
  localparam int unsigned OFFSCREEN_Y = 481;
  localparam int unsigned SCORE_MAX   = 9999;

  localparam int unsigned PTS_ROW_TOP = 30;
  localparam int unsigned PTS_ROW_MID = 20;
  localparam int unsigned PTS_ROW_LOW = 10;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} hit_state_t;

  // Top row scores most; rows 1-2 middle; everything below lowest.
  function automatic logic [13:0] row_points(input logic [7:0] row);
    if (row == 8'd0) begin
      return 14'(PTS_ROW_TOP);
    end else if (row <= 8'd2) begin
      return 14'(PTS_ROW_MID);
    end else begin
      return 14'(PTS_ROW_LOW);
    end
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned box overlap test on 11-bit screen coordinates.
module rect_overlap (
  input  logic [10:0] a_x_i,
  input  logic [10:0] a_y_i,
  input  logic [10:0] a_w_i,
  input  logic [10:0] a_h_i,
  input  logic [10:0] b_x_i,
  input  logic [10:0] b_y_i,
  input  logic [10:0] b_w_i,
  input  logic [10:0] b_h_i,
  output logic        overlap_o
);

  logic [11:0] a_r, a_b, b_r, b_b;
  logic        nonzero;

  assign a_r = {1'b0, a_x_i} + {1'b0, a_w_i};
  assign a_b = {1'b0, a_y_i} + {1'b0, a_h_i};
  assign b_r = {1'b0, b_x_i} + {1'b0, b_w_i};
  assign b_b = {1'b0, b_y_i} + {1'b0, b_h_i};

  // A zero-area box never overlaps anything.
  assign nonzero = (a_w_i != '0) && (a_h_i != '0) && (b_w_i != '0) && (b_h_i != '0);

  assign overlap_o = nonzero &&
                     ({1'b0, b_x_i} < a_r) && ({1'b0, a_x_i} < b_r) &&
                     ({1'b0, b_y_i} < a_b) && ({1'b0, a_y_i} < b_b);

endmodule

// File: rtl/alien_hit_detector.sv
// Per-frame scan of the player missile against the alien formation; owns the
// alive bitmap, live count and score, and drives the registered hit level.
module alien_hit_detector import invaders_pkg::*; #(
  parameter int unsigned ROWS      = 5,
  parameter int unsigned COLS      = 11,
  parameter int unsigned ALIEN_W   = 16,
  parameter int unsigned ALIEN_H   = 16,
  parameter int unsigned SPACING_X = 32,
  parameter int unsigned SPACING_Y = 24,
  parameter int unsigned MISSILE_W = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_start,
  input  logic                 wave_reset,
  input  logic [9:0]           missilex,
  input  logic [9:0]           missiley,
  input  logic [9:0]           missilesize,
  input  logic [9:0]           fleet_x,
  input  logic [9:0]           fleet_y,
  output logic                 hit,
  output logic [ROWS*COLS-1:0] alive,
  output logic [6:0]           alive_count,
  output logic                 all_dead,
  output logic [13:0]          score,
  output logic                 scan_busy,
  output logic                 overrun
);

  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLS);

  hit_state_t      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [9:0]      mx_q, mx_d, my_q, my_d, ms_q, ms_d, fx_q, fx_d, fy_q, fy_d;
  logic            hit_q, hit_d;
  logic [N-1:0]    alive_q, alive_d;
  logic [6:0]      count_q, count_d;
  logic [13:0]     score_q, score_d;
  logic            overrun_q, overrun_d;

  logic [10:0] ax, ay;
  logic        ovl;
  logic [14:0] score_sum;

  // Row/col counters track idx so no divider is needed for alien placement.
  assign ax = {1'b0, fx_q} + 11'(col_q) * 11'(SPACING_X);
  assign ay = {1'b0, fy_q} + 11'(row_q) * 11'(SPACING_Y);

  rect_overlap u_rect_overlap (
    .a_x_i     (ax),
    .a_y_i     (ay),
    .a_w_i     (11'(ALIEN_W)),
    .a_h_i     (11'(ALIEN_H)),
    .b_x_i     ({1'b0, mx_q}),
    .b_y_i     ({1'b0, my_q}),
    .b_w_i     (11'(MISSILE_W)),
    .b_h_i     ({1'b0, ms_q}),
    .overlap_o (ovl)
  );

  assign score_sum = {1'b0, score_q} + {1'b0, row_points(8'(row_q))};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    mx_d      = mx_q;
    my_d      = my_q;
    ms_d      = ms_q;
    fx_d      = fx_q;
    fy_d      = fy_q;
    hit_d     = hit_q;
    alive_d   = alive_q;
    count_d   = count_q;
    score_d   = score_q;
    overrun_d = overrun_q;

    if (wave_reset) begin
      state_d = IDLE;
      alive_d = '1;
      count_d = 7'(N);
      hit_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            mx_d  = missilex;
            my_d  = missiley;
            ms_d  = missilesize;
            fx_d  = fleet_x;
            fy_d  = fleet_y;
            hit_d = 1'b0;
            idx_d = '0;
            row_d = '0;
            col_d = '0;
            state_d = (missilex >= 10'(SCREEN_W) || missiley >= 10'(SCREEN_H)) ? DONE : SCAN;
          end
        end
        SCAN: begin
          if (frame_start) overrun_d = 1'b1;
          if (alive_q[idx_q] && ovl) begin
            alive_d[idx_q] = 1'b0;
            hit_d          = 1'b1;
            count_d        = count_q - 7'd1;
            score_d        = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
            state_d        = DONE;
          end else if (idx_q == IdxW'(N - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (col_q == ColW'(COLS - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (frame_start) overrun_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      ms_q      <= '0;
      fx_q      <= '0;
      fy_q      <= '0;
      hit_q     <= 1'b0;
      alive_q   <= '1;
      count_q   <= 7'(N);
      score_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      ms_q      <= ms_d;
      fx_q      <= fx_d;
      fy_q      <= fy_d;
      hit_q     <= hit_d;
      alive_q   <= alive_d;
      count_q   <= count_d;
      score_q   <= score_d;
      overrun_q <= overrun_d;
    end
  end

  assign hit         = hit_q;
  assign alive       = alive_q;
  assign alive_count = count_q;
  assign all_dead    = (count_q == '0);
  assign score       = score_q;
  assign scan_busy   = (state_q == SCAN);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_alien_hit_detector.sv
// Directed-vector bench for alien_hit_detector with a small alive/score model.
module tb_alien_hit_detector;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic        wave_reset;
  logic [9:0]  missilex, missiley, missilesize, fleet_x, fleet_y;
  logic        hit;
  logic [54:0] alive;
  logic [6:0]  alive_count;
  logic        all_dead;
  logic [13:0] score;
  logic        scan_busy;
  logic        overrun;

  int n_chk  = 0;
  int n_fail = 0;

  logic [54:0] exp_alive;
  int          exp_count;
  int          exp_score;

  typedef struct {
    int mx;
    int my;
    int sz;
    int kill;  // expected killed index, -1 for none
  } vec_t;

  vec_t vecs[15];

  alien_hit_detector dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .wave_reset  (wave_reset),
    .missilex    (missilex),
    .missiley    (missiley),
    .missilesize (missilesize),
    .fleet_x     (fleet_x),
    .fleet_y     (fleet_y),
    .hit         (hit),
    .alive       (alive),
    .alive_count (alive_count),
    .all_dead    (all_dead),
    .score       (score),
    .scan_busy   (scan_busy),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pts(input int idx);
    int r;
    r = idx / 11;
    if (r == 0) return 30;
    if (r <= 2) return 20;
    return 10;
  endfunction

  task automatic model_kill(input int idx);
    exp_alive[idx] = 1'b0;
    exp_count--;
    exp_score += pts(idx);
    if (exp_score > 9999) exp_score = 9999;
  endtask

  // Drive one frame and wait (bounded) for the scan to return to IDLE.
  task automatic run_frame(input int mx, input int my, input int sz);
    bit done;
    done = 1'b0;
    @(negedge Clk);
    missilex    = 10'(mx);
    missiley    = 10'(my);
    missilesize = 10'(sz);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    for (int i = 0; i < 70 && !done; i++) begin
      if (!scan_busy) done = 1'b1;
      else @(negedge Clk);
    end
    chk("scan_done", 64'(done), 64'd1);
    @(negedge Clk);
  endtask

  task automatic kill_at(input int idx);
    run_frame(100 + 32 * (idx % 11) + 5, 50 + 24 * (idx / 11) + 2, 8);
  endtask

  task automatic pulse_wave_reset();
    @(negedge Clk);
    wave_reset = 1'b1;
    @(negedge Clk);
    wave_reset = 1'b0;
  endtask

  initial begin
    // fleet at (100,50): alien idx k at x=100+32*col, y=50+24*row
    vecs[0]  = '{641, 481, 8, -1};   // off screen
    vecs[1]  = '{105, 60, 8, 0};
    vecs[2]  = '{105, 60, 8, -1};    // idx 0 already dead
    vecs[3]  = '{137, 60, 40, 1};    // spans idx 1 and 12, first wins
    vecs[4]  = '{137, 60, 40, 12};
    vecs[5]  = '{137, 60, 0, -1};    // zero height
    vecs[6]  = '{425, 148, 8, 54};   // row 4
    vecs[7]  = '{640, 60, 8, -1};    // x at screen width
    vecs[8]  = '{105, 480, 8, -1};   // y at screen height
    vecs[9]  = '{162, 60, 8, -1};    // right edge touches ax=164
    vecs[10] = '{163, 60, 8, 2};
    vecs[11] = '{212, 60, 8, -1};    // left edge at ax+16 of idx 3
    vecs[12] = '{211, 60, 8, 3};
    vecs[13] = '{229, 42, 8, -1};    // bottom edge touches ay=50
    vecs[14] = '{229, 43, 8, 4};

    Reset_n = 1'b0; frame_start = 1'b0; wave_reset = 1'b0;
    missilex = 10'd641; missiley = 10'd481; missilesize = 10'd8;
    fleet_x = 10'd100; fleet_y = 10'd50;
    exp_alive = '1; exp_count = 55; exp_score = 0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_alive", 64'(alive), 64'(exp_alive));
    chk("rst_count", 64'(alive_count), 64'd55);
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_busy", 64'(scan_busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    for (int v = 0; v < 15; v++) begin
      run_frame(vecs[v].mx, vecs[v].my, vecs[v].sz);
      if (vecs[v].kill >= 0) model_kill(vecs[v].kill);
      chk($sformatf("v%0d_hit", v), 64'(hit), (vecs[v].kill >= 0) ? 64'd1 : 64'd0);
      chk($sformatf("v%0d_alive", v), 64'(alive), 64'(exp_alive));
      chk($sformatf("v%0d_count", v), 64'(alive_count), 64'(exp_count));
      chk($sformatf("v%0d_score", v), 64'(score), 64'(exp_score));
    end

    // Overrun: second frame_start while scanning a miss.
    @(negedge Clk);
    missilex = 10'd600; missiley = 10'd400; missilesize = 10'd8;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    chk("ovr_busy", 64'(scan_busy), 64'd1);
    chk("ovr_before", 64'(overrun), 64'd0);
    repeat (3) @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    chk("ovr_set", 64'(overrun), 64'd1);
    chk("ovr_still_busy", 64'(scan_busy), 64'd1);
    repeat (60) @(negedge Clk);
    chk("ovr_done", 64'(scan_busy), 64'd0);

    // wave_reset mid-scan restores the formation, keeps the score.
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (5) @(negedge Clk);
    chk("wr_busy_before", 64'(scan_busy), 64'd1);
    pulse_wave_reset();
    exp_alive = '1; exp_count = 55;
    chk("wr_busy", 64'(scan_busy), 64'd0);
    chk("wr_alive", 64'(alive), 64'(exp_alive));
    chk("wr_count", 64'(alive_count), 64'd55);
    chk("wr_score", 64'(score), 64'(exp_score));
    chk("wr_overrun_sticky", 64'(overrun), 64'd1);

    // Missile spans idx 0 and 11: only idx 0 dies.
    run_frame(105, 60, 40);
    model_kill(0);
    chk("two_hit", 64'(hit), 64'd1);
    chk("two_alive", 64'(alive), 64'(exp_alive));
    chk("two_alive11", 64'(alive[11]), 64'd1);
    chk("two_score", 64'(score), 64'(exp_score));

    pulse_wave_reset();
    exp_alive = '1; exp_count = 55;
    chk("wr_idle_hit", 64'(hit), 64'd0);
    chk("wr_idle_alive", 64'(alive), 64'(exp_alive));

    // Async reset in the middle of a scan.
    @(negedge Clk);
    missilex = 10'd600; missiley = 10'd400; missilesize = 10'd8;
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(scan_busy), 64'd0);
    chk("arst_score", 64'(score), 64'd0);
    chk("arst_overrun", 64'(overrun), 64'd0);
    chk("arst_count", 64'(alive_count), 64'd55);
    @(negedge Clk);
    Reset_n = 1'b1;
    exp_alive = '1; exp_count = 55; exp_score = 0;

    // Ten full waves of 990 points each, then top up to 9990.
    for (int w = 0; w < 10; w++) begin
      for (int k = 0; k < 55; k++) begin
        kill_at(k);
        model_kill(k);
      end
      if (w == 0) begin
        chk("wave_all_dead", 64'(all_dead), 64'd1);
        chk("wave_count0", 64'(alive_count), 64'd0);
      end
      pulse_wave_reset();
      exp_alive = '1; exp_count = 55;
    end
    chk("sat_9900", 64'(score), 64'(exp_score));
    for (int k = 0; k < 3; k++) begin
      kill_at(k);
      model_kill(k);
    end
    chk("sat_9990", 64'(score), 64'd9990);
    kill_at(44);
    model_kill(44);
    chk("sat_row4_hit", 64'(hit), 64'd1);
    chk("sat_row4", 64'(score), 64'd9999);
    kill_at(3);
    model_kill(3);
    chk("sat_row0_hit", 64'(hit), 64'd1);
    chk("sat_row0", 64'(score), 64'd9999);
    chk("sat_alive", 64'(alive), 64'(exp_alive));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
